// File: rtl/fp_mc_ctrl_pkg.sv
// Shared encodings and latency lookup for the multi-cycle FP op sequencer.
// The FP op class encodings and FSM states are used by the controller, its counter and the bus interface.
package fp_mc_ctrl_pkg;

  typedef enum logic [1:0] {
    FP_OP_NONE = 2'b00,
    FP_OP_MUL  = 2'b01,
    FP_OP_DIV  = 2'b10,
    FP_OP_SQRT = 2'b11
  } fp_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } fp_state_e;

  // Single-cycle ops report 2 so that (latency - 2) loads a harmless zero.
  function automatic int unsigned op_latency(input fp_op_e op,
                                             input int unsigned mul_lat,
                                             input int unsigned div_lat,
                                             input int unsigned sqrt_lat);
    int unsigned lat;
    case (op)
      FP_OP_MUL:  lat = mul_lat;
      FP_OP_DIV:  lat = div_lat;
      FP_OP_SQRT: lat = sqrt_lat;
      default:    lat = 2;
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/fp_mc_ctrl_if.sv
// Pipeline-side handshake between the Execute/Memory control and the multi-cycle FP sequencer.
// The master modport is the pipeline and the slave modport is the controller.
interface fp_mc_ctrl_if;
  import fp_mc_ctrl_pkg::*;

  logic   FpValidE;
  fp_op_e FpOpE;
  logic   FlushE;
  logic   MemStall;

  logic   FpStart;
  logic   FpAbort;
  fp_op_e FpOpSel;
  logic   StallF;
  logic   StallD;
  logic   StallE;
  logic   BubbleM;
  logic   FpResultValid;
  logic   FpBusy;

  modport master (
    output FpValidE, FpOpE, FlushE, MemStall,
    input  FpStart, FpAbort, FpOpSel, StallF, StallD, StallE,
           BubbleM, FpResultValid, FpBusy
  );

  modport slave (
    input  FpValidE, FpOpE, FlushE, MemStall,
    output FpStart, FpAbort, FpOpSel, StallF, StallD, StallE,
           BubbleM, FpResultValid, FpBusy
  );
endinterface

// File: rtl/mc_lat_counter.sv
// Latency counter for the in-flight FP op: loads LAT-2 on accept, counts down to zero, never wraps.
module mc_lat_counter
  import fp_mc_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT  = 3,
  parameter int unsigned DIV_LAT  = 16,
  parameter int unsigned SQRT_LAT = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  fp_op_e load_op,
  input  logic   dec,
  input  logic   clr,
  output logic   zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] load_val;

  // The accept cycle and the DONE cycle are outside the count, hence LAT-2.
  always_comb load_val = CNT_W'(op_latency(load_op, MUL_LAT, DIV_LAT, SQRT_LAT) - 2);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/fp_mc_ctrl.sv
// Multi-cycle FMUL/FDIV/FSQRT sequencer: holds F/D/E, bubbles M, and releases the op exactly when its result is ready.
module fp_mc_ctrl
  import fp_mc_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT  = 3,
  parameter int unsigned DIV_LAT  = 16,
  parameter int unsigned SQRT_LAT = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic         clk,
  input  logic         reset,
  fp_mc_ctrl_if.slave  bus
);

  fp_state_e state_q;
  fp_state_e state_d;
  fp_op_e    op_sel_q;
  fp_op_e    op_sel_d;

  logic accept;
  logic cnt_zero;
  logic cnt_load;
  logic cnt_dec;
  logic cnt_clr;
  logic start;
  logic abort;
  logic stall;
  logic bubble;
  logic valid;

  assign accept = (state_q == S_IDLE) && bus.FpValidE &&
                  (bus.FpOpE != FP_OP_NONE) && !bus.FlushE;

  mc_lat_counter #(
    .MUL_LAT  (MUL_LAT),
    .DIV_LAT  (DIV_LAT),
    .SQRT_LAT (SQRT_LAT),
    .CNT_W    (CNT_W)
  ) u_lat_counter (
    .clk     (clk),
    .reset   (reset),
    .load    (cnt_load),
    .load_op (bus.FpOpE),
    .dec     (cnt_dec),
    .clr     (cnt_clr),
    .zero    (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    op_sel_d = op_sel_q;
    start    = 1'b0;
    abort    = 1'b0;
    stall    = 1'b0;
    bubble   = 1'b0;
    valid    = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_clr  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          start    = 1'b1;
          stall    = 1'b1;
          bubble   = 1'b1;
          cnt_load = 1'b1;
          op_sel_d = bus.FpOpE;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        if (bus.FlushE) begin
          abort    = 1'b1;
          cnt_clr  = 1'b1;
          op_sel_d = FP_OP_NONE;
          state_d  = S_IDLE;
        end else begin
          stall  = 1'b1;
          bubble = 1'b1;
          if (cnt_zero) begin
            state_d = S_DONE;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (bus.FlushE) begin
          abort    = 1'b1;
          cnt_clr  = 1'b1;
          op_sel_d = FP_OP_NONE;
          state_d  = S_IDLE;
        end else begin
          // Result stays valid while Memory is stalled; the hazard unit holds the M register.
          valid = 1'b1;
          if (bus.MemStall) begin
            stall = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_sel_q <= FP_OP_NONE;
    end else begin
      state_q  <= state_d;
      op_sel_q <= op_sel_d;
    end
  end

  // Combinational outputs are forced low while reset is held, even if Execute presents an op.
  assign bus.FpStart       = reset & start;
  assign bus.FpAbort       = reset & abort;
  assign bus.StallF        = reset & stall;
  assign bus.StallD        = reset & stall;
  assign bus.StallE        = reset & stall;
  assign bus.BubbleM       = reset & bubble;
  assign bus.FpResultValid = reset & valid;
  assign bus.FpOpSel       = op_sel_q;
  assign bus.FpBusy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_fp_mc_ctrl.sv
// Self-checking bench for fp_mc_ctrl: directed scenarios plus random traffic against an op-age reference model.
module tb_fp_mc_ctrl;
  import fp_mc_ctrl_pkg::*;

  localparam int MUL_LAT  = 3;
  localparam int DIV_LAT  = 16;
  localparam int SQRT_LAT = 16;

  logic clk;
  logic reset;

  fp_mc_ctrl_if ifc ();

  fp_mc_ctrl #(
    .MUL_LAT  (MUL_LAT),
    .DIV_LAT  (DIV_LAT),
    .SQRT_LAT (SQRT_LAT),
    .CNT_W    (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  int starts_seen = 0;
  int valids_seen = 0;

  // Reference model: whether an op is in flight, its class, and cycles elapsed since acceptance.
  bit m_busy  = 1'b0;
  int m_op    = 0;
  int m_opsel = 0;
  int m_age   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic int lat_of(input int op);
    case (op)
      1:       return MUL_LAT;
      2:       return DIV_LAT;
      3:       return SQRT_LAT;
      default: return 0;
    endcase
  endfunction

  task automatic check_outputs();
    bit e_start = 0, e_abort = 0, e_stall = 0, e_bub = 0, e_valid = 0, e_busy = 0;
    int e_opsel = 0;
    int op_in;
    op_in = int'(ifc.FpOpE);
    if (reset) begin
      e_opsel = m_opsel;
      if (!m_busy) begin
        e_start = ifc.FpValidE && (op_in != 0) && !ifc.FlushE;
        e_stall = e_start;
        e_bub   = e_start;
      end else begin
        e_busy = 1'b1;
        if (ifc.FlushE) begin
          e_abort = 1'b1;
        end else if (m_age < lat_of(m_op)) begin
          e_stall = 1'b1;
          e_bub   = 1'b1;
        end else begin
          e_valid = 1'b1;
          e_stall = ifc.MemStall;
        end
      end
    end
    check_eq("FpStart",       ifc.FpStart,       e_start);
    check_eq("FpAbort",       ifc.FpAbort,       e_abort);
    check_eq("FpOpSel",       ifc.FpOpSel,       e_opsel);
    check_eq("StallF",        ifc.StallF,        e_stall);
    check_eq("StallD",        ifc.StallD,        e_stall);
    check_eq("StallE",        ifc.StallE,        e_stall);
    check_eq("BubbleM",       ifc.BubbleM,       e_bub);
    check_eq("FpResultValid", ifc.FpResultValid, e_valid);
    check_eq("FpBusy",        ifc.FpBusy,        e_busy);
    starts_seen += int'(ifc.FpStart);
    valids_seen += int'(ifc.FpResultValid);
  endtask

  task automatic update_model();
    int op_in;
    op_in = int'(ifc.FpOpE);
    if (!reset) begin
      m_busy  = 1'b0;
      m_opsel = 0;
      m_age   = 0;
    end else if (!m_busy) begin
      if (ifc.FpValidE && (op_in != 0) && !ifc.FlushE) begin
        m_busy  = 1'b1;
        m_op    = op_in;
        m_opsel = op_in;
        m_age   = 1;
      end
    end else if (ifc.FlushE) begin
      $display("op %0d aborted at cycle %0d after %0d cycles", m_op, cycle, m_age);
      m_busy  = 1'b0;
      m_opsel = 0;
    end else if ((m_age >= lat_of(m_op)) && !ifc.MemStall) begin
      $display("op %0d completed at cycle %0d after %0d cycles", m_op, cycle, m_age);
      m_busy = 1'b0;
    end else begin
      m_age++;
    end
  endtask

  // Called just after a rising edge: drive inputs, check mid-cycle, advance model at the next edge.
  task automatic step(input bit v, input int op, input bit fl, input bit ms);
    ifc.FpValidE = v;
    ifc.FpOpE    = fp_op_e'(op[1:0]);
    ifc.FlushE   = fl;
    ifc.MemStall = ms;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    update_model();
    cycle++;
    #1;
  endtask

  initial begin
    int s0, v0;
    reset = 1'b0;
    ifc.FpValidE = 1'b0;
    ifc.FpOpE    = FP_OP_NONE;
    ifc.FlushE   = 1'b0;
    ifc.MemStall = 1'b0;
    @(posedge clk);
    #1;
    step(1, 2, 0, 0);
    step(0, 0, 0, 0);
    reset = 1'b1;
    step(0, 0, 0, 0);

    // Reset mid-FDIV while the counter holds 7.
    step(1, 2, 0, 0);
    repeat (7) step(0, 0, 0, 0);
    ifc.FpValidE = 1'b1;
    ifc.FpOpE    = FP_OP_MUL;
    reset = 1'b0;
    #1;
    check_eq("rst_FpBusy",  ifc.FpBusy,        0);
    check_eq("rst_StallE",  ifc.StallE,        0);
    check_eq("rst_BubbleM", ifc.BubbleM,       0);
    check_eq("rst_FpStart", ifc.FpStart,       0);
    check_eq("rst_OpSel",   ifc.FpOpSel,       0);
    check_eq("rst_Valid",   ifc.FpResultValid, 0);
    @(posedge clk);
    update_model();
    #1;
    step(1, 1, 0, 0);
    reset = 1'b1;
    repeat (2) step(0, 0, 0, 0);

    // FMUL with default timing.
    step(1, 1, 0, 0);
    repeat (4) step(0, 0, 0, 0);

    // FDIV held in DONE by two Memory stall cycles.
    step(1, 2, 0, 0);
    repeat (15) step(0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 1);
    repeat (2) step(0, 0, 0, 0);

    // FSQRT killed at T+5.
    step(1, 3, 0, 0);
    repeat (4) step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    repeat (2) step(0, 0, 0, 0);

    // Back-to-back FMULs.
    s0 = starts_seen;
    v0 = valids_seen;
    repeat (8) step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    check_eq("b2b_starts", starts_seen - s0, 2);
    check_eq("b2b_valids", valids_seen - v0, 2);

    // Single-cycle op and flushed FDIV must not start anything.
    repeat (3) step(1, 0, 0, 0);
    repeat (3) step(1, 2, 1, 0);

    repeat (3000) begin
      reset = ($urandom_range(0, 299) != 0);
      step($urandom_range(0, 99) < 60, int'($urandom_range(0, 3)),
           $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 30);
    end
    reset = 1'b1;
    repeat (20) step(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
